// File: rtl/dma_desc_wr_engine.sv
// DMA descriptor write engine: pops descriptors, drains payload words to memory, pulses completion.
// Optional alignment checking (err output) is enabled with `define DMA_ALIGN_CHK_EN.
module dma_desc_wr_engine #(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    desc_empty,
    input  logic [LEN_W+ADDR_W-1:0] desc_dout,
    output logic                    desc_rd_en,
    input  logic                    data_valid,
    input  logic [31:0]             data,
    output logic                    data_ready,
    output logic                    mem_wren,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_wstrb,
    input  logic                    mem_gnt,
    output logic                    done_valid,
    output logic [LEN_W-1:0]        done_len,
`ifdef DMA_ALIGN_CHK_EN
    output logic                    err,
`endif
    output logic                    busy
);

    localparam int WL_W = LEN_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [LEN_W-1:0]    len_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [WL_W-1:0]     words_left_r;
    logic [WL_W-1:0]     beat_r;
    logic                desc_rd_en_r;
    logic                mem_wren_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic [3:0]          mem_wstrb_r;
    logic                done_valid_r;
    logic [LEN_W-1:0]    done_len_r;
    logic                busy_r;
`ifdef DMA_ALIGN_CHK_EN
    logic                err_r;
`endif
    logic                ready_s;
    logic                accept_s;
    logic [ADDR_W-1:0]   beat_off_s;
    logic [LEN_W-1:0]    head_len_s;
    logic [ADDR_W-1:0]   head_addr_s;

    // ceil(len/4) evaluated one bit wider so len near the top does not overflow
    function automatic logic [WL_W-1:0] word_count(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(3);
        return sum[LEN_W:2];
    endfunction

    function automatic logic [3:0] tail_strb(input logic [1:0] rem);
        logic [3:0] strb;
        case (rem)
            2'd1:    strb = 4'h1;
            2'd2:    strb = 4'h3;
            2'd3:    strb = 4'h7;
            default: strb = 4'hF;
        endcase
        return strb;
    endfunction

    assign head_len_s  = desc_dout[LEN_W+ADDR_W-1:ADDR_W];
    assign head_addr_s = desc_dout[ADDR_W-1:0];
    assign beat_off_s  = {{(ADDR_W-WL_W-2){1'b0}}, beat_r, 2'b00};

    // Stream handshake: a write still waiting for its grant blocks the next word
    always_comb begin
        ready_s = 1'b0;
        if (state_r == XFER && words_left_r != '0) begin
            ready_s = !mem_wren_r || mem_gnt;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign accept_s   = data_valid && ready_s;
    assign data_ready = ready_s;

    // Descriptor FSM, memory write request and completion registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            len_r        <= '0;
            addr_r       <= '0;
            words_left_r <= '0;
            beat_r       <= '0;
            desc_rd_en_r <= 1'b0;
            mem_wren_r   <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'h0000_0000;
            mem_wstrb_r  <= 4'h0;
            done_valid_r <= 1'b0;
            done_len_r   <= '0;
            busy_r       <= 1'b0;
`ifdef DMA_ALIGN_CHK_EN
            err_r        <= 1'b0;
`endif
        end else begin
            desc_rd_en_r <= 1'b0;
            done_valid_r <= 1'b0;
`ifdef DMA_ALIGN_CHK_EN
            err_r        <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (!desc_empty) begin
                        len_r        <= head_len_s;
                        addr_r       <= head_addr_s & {{(ADDR_W-2){1'b1}}, 2'b00};
                        words_left_r <= word_count(head_len_s);
                        beat_r       <= '0;
                        desc_rd_en_r <= 1'b1;
                        busy_r       <= 1'b1;
`ifdef DMA_ALIGN_CHK_EN
                        if (head_addr_s[1:0] != 2'b00) begin
                            words_left_r <= '0;
                            state_r      <= DONE;
                            done_valid_r <= 1'b1;
                            done_len_r   <= '0;
                            err_r        <= 1'b1;
                        end else
`endif
                        if (head_len_s == '0) begin
                            state_r      <= DONE;
                            done_valid_r <= 1'b1;
                            done_len_r   <= '0;
                        end else begin
                            state_r <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (accept_s) begin
                        mem_wren_r   <= 1'b1;
                        mem_addr_r   <= addr_r + beat_off_s;
                        mem_wdata_r  <= data;
                        mem_wstrb_r  <= (words_left_r == WL_W'(1)) ? tail_strb(len_r[1:0]) : 4'hF;
                        words_left_r <= words_left_r - WL_W'(1);
                        beat_r       <= beat_r + WL_W'(1);
                    end else if (mem_wren_r && mem_gnt) begin
                        mem_wren_r <= 1'b0;
                        if (words_left_r == '0) begin
                            state_r      <= DONE;
                            done_valid_r <= 1'b1;
                            done_len_r   <= len_r;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign desc_rd_en = desc_rd_en_r;
    assign mem_wren   = mem_wren_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wstrb  = mem_wstrb_r;
    assign done_valid = done_valid_r;
    assign done_len   = done_len_r;
    assign busy       = busy_r;
`ifdef DMA_ALIGN_CHK_EN
    assign err        = err_r;
`endif

endmodule
